// File: rtl/axi_tlast_pkg.sv
// -----------------------------------------------------------------------------
// axi_tlast_pkg
// Shared constants and types for the in-band TLAST encoder (axi_embed_tlast)
// and its matching decoder (axi_extract_tlast).
//   ESC_CODE   default escape word that introduces an ESC+FLAG+DATA triple
//   FLAG_LAST  FLAG[31:0] value when the escaped word carried TLAST
//   FLAG_EMUL  FLAG[31:0] value when the escaped word was a payload ESC
//   tlast_state_t  encoder/decoder sequence states
//   fold64     folds a 64-bit word to the 32-bit checksum contribution
// -----------------------------------------------------------------------------
package axi_tlast_pkg;

  localparam logic [63:0] ESC_CODE  = 64'hDEADBEEFFEEDCAFE;
  localparam logic [31:0] FLAG_LAST = 32'h0000_0001;
  localparam logic [31:0] FLAG_EMUL = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // pass-through, or emitting ESC for the current word
    ST_FLAG = 2'd1,  // emitting the FLAG word
    ST_DATA = 2'd2   // emitting the escaped word itself
  } tlast_state_t;

  function automatic logic [31:0] fold64(input logic [63:0] d);
    return d[63:32] ^ d[31:0];
  endfunction

endpackage

// File: rtl/axi_tlast_xor_csum.sv
// -----------------------------------------------------------------------------
// axi_tlast_xor_csum
// 32-bit XOR accumulator used for the per-packet checksum.
//   clk       clock
//   rst       asynchronous active-high reset (clears the accumulator)
//   i_clear   synchronous clear, wins over i_update
//   i_update  XOR i_data into the accumulator this cycle
//   i_data    32-bit contribution
//   o_csum    current accumulator value
// -----------------------------------------------------------------------------
module axi_tlast_xor_csum (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_update,
  input  logic [31:0] i_data,
  output logic [31:0] o_csum
);

  logic [31:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (i_update) begin
      r_csum <= r_csum ^ i_data;
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/axi_embed_tlast.sv
// -----------------------------------------------------------------------------
// axi_embed_tlast
// Encodes TLAST in-band so a packet stream can cross a link with no sideband
// bit. Every word with TLAST, and every payload word equal to ESC, is sent as
// ESC, FLAG, DATA. FLAG[0] is the original TLAST; FLAG[63:32] optionally
// carries the XOR checksum of the packet's non-last words seen so far.
//   clk       clock
//   reset     asynchronous active-high reset
//   clear     synchronous clear, same effect as reset
//   i_tdata   input payload          i_tlast   input end of packet
//   i_tvalid  input valid            i_tready  input ready (output)
//   o_tdata   encoded word           o_tvalid  output valid
//   o_tready  output ready (input)
// The datapath is combinational; only state, checksum and flag_last register.
// -----------------------------------------------------------------------------
module axi_embed_tlast
  import axi_tlast_pkg::*;
#(
  parameter int          WIDTH          = 64,
  parameter bit          EMBED_CHECKSUM = 1'b0,
  parameter logic [63:0] ESC            = ESC_CODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  if (WIDTH != 64) begin : g_width_check
    $error("axi_embed_tlast: only WIDTH=64 is supported");
  end

  tlast_state_t r_state;
  tlast_state_t w_state_next;
  logic         r_flag_last;

  logic         w_esc_needed;
  logic         w_in_fire;
  logic         w_csum_clear;
  logic         w_csum_update;
  logic [31:0]  w_csum;
  logic [31:0]  w_csum_field;

  assign w_esc_needed = i_tvalid & (i_tlast | (i_tdata == ESC));
  assign w_in_fire    = i_tvalid & i_tready;

  // A word is only ever accepted once (in IDLE when plain, in DATA when
  // escaped), so an escaped ESC payload contributes exactly once.
  assign w_csum_update = w_in_fire & ~i_tlast;
  assign w_csum_clear  = clear | (w_in_fire & i_tlast);

  axi_tlast_xor_csum u_csum (
    .clk      (clk),
    .rst      (reset),
    .i_clear  (w_csum_clear),
    .i_update (w_csum_update),
    .i_data   (fold64(i_tdata)),
    .o_csum   (w_csum)
  );

  assign w_csum_field = EMBED_CHECKSUM ? w_csum : 32'h0;

  always_comb begin
    w_state_next = r_state;
    o_tdata      = i_tdata;
    o_tvalid     = i_tvalid;
    i_tready     = o_tready;
    unique case (r_state)
      ST_IDLE: begin
        if (w_esc_needed) begin
          o_tdata  = ESC;
          o_tvalid = 1'b1;
          i_tready = 1'b0;
          if (o_tready) begin
            w_state_next = ST_FLAG;
          end
        end
      end
      ST_FLAG: begin
        // Built from the latched flag so a misbehaving upstream cannot
        // change the meaning of a FLAG already being presented.
        o_tdata  = {w_csum_field, (r_flag_last ? FLAG_LAST : FLAG_EMUL)};
        o_tvalid = 1'b1;
        i_tready = 1'b0;
        if (o_tready) begin
          w_state_next = ST_FLAG == ST_FLAG ? ST_DATA : ST_FLAG;
        end
      end
      ST_DATA: begin
        if (i_tvalid && o_tready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flag_last <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_flag_last <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && w_esc_needed && o_tready) begin
        r_flag_last <= i_tlast;
      end
    end
  end

endmodule

// File: tb/tb_axi_embed_tlast.sv
// -----------------------------------------------------------------------------
// tb_axi_embed_tlast
// Drives two encoders (checksum embedded / not embedded) from one stimulus.
// Directed packets are checked against hand-computed words; a randomized
// phase is checked against a stream-level model and a behavioural decoder.
// -----------------------------------------------------------------------------
module tb_axi_embed_tlast;

  localparam logic [63:0] ESC = 64'hDEADBEEFFEEDCAFE;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        o_tready;
  logic        i_tready_c, o_tvalid_c, i_tready_n, o_tvalid_n;
  logic [63:0] o_tdata_c, o_tdata_n;

  always #5 clk = ~clk;

  axi_embed_tlast #(.WIDTH(64), .EMBED_CHECKSUM(1'b1), .ESC(ESC)) dut_c (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready_c),
    .o_tdata(o_tdata_c), .o_tvalid(o_tvalid_c), .o_tready(o_tready)
  );

  axi_embed_tlast #(.WIDTH(64), .EMBED_CHECKSUM(1'b0), .ESC(ESC)) dut_n (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready_n),
    .o_tdata(o_tdata_n), .o_tvalid(o_tvalid_n), .o_tready(o_tready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [31:0] fold(input logic [63:0] d);
    return d[63:32] ^ d[31:0];
  endfunction

  // ---------------- directed packets ----------------
  logic [63:0] dir_d[$];
  bit          dir_l[$];
  logic [63:0] exp_c[$];
  logic [63:0] exp_n[$];

  task automatic run_dir(input string name);
    logic [63:0] got_c[$];
    logic [63:0] got_n[$];
    int idx = 0;
    int cyc = 0;
    o_tready = 1'b1;
    while (idx < dir_d.size() && cyc < 100) begin
      i_tvalid = 1'b1;
      i_tdata  = dir_d[idx];
      i_tlast  = dir_l[idx];
      @(negedge clk);
      if (o_tvalid_c && o_tready) got_c.push_back(o_tdata_c);
      if (o_tvalid_n && o_tready) got_n.push_back(o_tdata_n);
      if (i_tvalid && i_tready_c) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    chk({name, " words_in"}, idx, dir_d.size());
    chk({name, " count_c"}, got_c.size(), exp_c.size());
    chk({name, " count_n"}, got_n.size(), exp_n.size());
    for (int k = 0; k < exp_c.size(); k++)
      chk($sformatf("%s c[%0d]", name, k), (k < got_c.size()) ? got_c[k] : 64'hx, exp_c[k]);
    for (int k = 0; k < exp_n.size(); k++)
      chk($sformatf("%s n[%0d]", name, k), (k < got_n.size()) ? got_n[k] : 64'hx, exp_n[k]);
    $display("directed %s: %0d in, %0d/%0d out", name, idx, got_c.size(), got_n.size());
    dir_d.delete(); dir_l.delete(); exp_c.delete(); exp_n.delete();
  endtask

  // ---------------- random phase: model + monitor ----------------
  logic [63:0] src_d[$];
  bit          src_l[$];
  logic [63:0] sb_c[$];
  logic [63:0] sb_n[$];
  bit          check_en  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  int          dec_st  = 0;
  int          dec_idx = 0;
  logic [63:0] dec_flag = '0;
  logic [31:0] dec_csum = '0;

  always @(negedge clk) begin
    if (check_en) begin
      if (prev_stall) begin
        chk("stall valid", {63'b0, o_tvalid_c}, 64'd1);
        chk("stall data", o_tdata_c, prev_data);
      end
      prev_stall = o_tvalid_c & ~o_tready;
      prev_data  = o_tdata_c;
      if (o_tvalid_c && o_tready) begin
        if (sb_c.size() == 0) chk("rnd c extra", o_tdata_c, 64'hx);
        else chk("rnd c", o_tdata_c, sb_c.pop_front());
        // Behavioural decoder restoring TLAST and checking the checksum
        if (dec_st == 1) begin
          dec_flag = o_tdata_c;
          chk("dec csum", {32'b0, dec_flag[63:32]}, {32'b0, dec_csum});
          dec_st = 2;
        end else if (dec_st == 0 && o_tdata_c == ESC) begin
          dec_st = 1;
        end else begin
          bit last;
          last = (dec_st == 2) ? dec_flag[0] : 1'b0;
          dec_st = 0;
          if (dec_idx < src_d.size()) begin
            chk("dec word", o_tdata_c, src_d[dec_idx]);
            chk("dec last", {63'b0, last}, {63'b0, src_l[dec_idx]});
          end else begin
            chk("dec extra", o_tdata_c, 64'hx);
          end
          dec_idx++;
          dec_csum = last ? 32'h0 : (dec_csum ^ fold(o_tdata_c));
        end
      end
      if (o_tvalid_n && o_tready) begin
        if (sb_n.size() == 0) chk("rnd n extra", o_tdata_n, 64'hx);
        else chk("rnd n", o_tdata_n, sb_n.pop_front());
      end
    end
  end

  localparam logic [63:0] A = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B = 64'h0000_00FF_0000_0F00;
  localparam logic [63:0] C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P = 64'h0000_0003_0000_0000;
  localparam logic [63:0] V = 64'h0000_0000_0000_0042;

  initial begin
    logic [31:0] csum;
    int idx;
    int cyc;
    bit fire;

    reset = 1'b1; clear = 1'b0;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = 64'h0000_0000_0000_CAFE;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: IDLE pass-through equations
    @(negedge clk);
    chk("rst o_tvalid", {63'b0, o_tvalid_c}, 64'd0);
    chk("rst i_tready", {63'b0, i_tready_c}, 64'd1);
    chk("rst o_tdata", o_tdata_c, 64'h0000_0000_0000_CAFE);
    o_tready = 1'b0;
    #1 chk("rst i_tready follows", {63'b0, i_tready_c}, 64'd0);
    @(posedge clk); #1;

    // Plain 3-word packet
    dir_d = '{A, B, C}; dir_l = '{0, 0, 1};
    exp_c = '{A, B, ESC, 64'h22226999_00000001, C};
    exp_n = '{A, B, ESC, 64'h1, C};
    run_dir("plain");

    // Payload ESC mid-packet, then an unescaped word, then last
    dir_d = '{64'h0000_0001_0000_0010, ESC, 64'h5, 64'hAAAA}; dir_l = '{0, 0, 0, 1};
    exp_c = '{64'h0000_0001_0000_0010, ESC, 64'h00000011_00000000, ESC, 64'h5,
              ESC, 64'h20407405_00000001, 64'hAAAA};
    exp_n = '{64'h0000_0001_0000_0010, ESC, 64'h0, ESC, 64'h5, ESC, 64'h1, 64'hAAAA};
    run_dir("esc_mid");

    // Single-word packet, checksum restarts from 0
    dir_d = '{64'h1234567887654321}; dir_l = '{1};
    exp_c = '{ESC, 64'h1, 64'h1234567887654321};
    exp_n = '{ESC, 64'h1, 64'h1234567887654321};
    run_dir("single");

    // ESC word carrying last
    dir_d = '{ESC}; dir_l = '{1};
    exp_c = '{ESC, 64'h1, ESC};
    exp_n = '{ESC, 64'h1, ESC};
    run_dir("esc_last");

    // Clear between packets wipes a pending checksum
    i_tvalid = 1'b1; i_tdata = P; i_tlast = 1'b0; o_tready = 1'b1;
    @(negedge clk);
    chk("clr pre word", o_tdata_c, P);
    @(posedge clk); #1;
    i_tvalid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    dir_d = '{A, B, C}; dir_l = '{0, 0, 1};
    exp_c = '{A, B, ESC, 64'h22226999_00000001, C};
    exp_n = '{A, B, ESC, 64'h1, C};
    run_dir("after_clear");

    // Reset while stalled in FLAG
    i_tvalid = 1'b1; i_tdata = P; i_tlast = 1'b0; o_tready = 1'b1;
    @(posedge clk); #1;
    i_tdata = V; i_tlast = 1'b1;
    @(negedge clk);
    chk("rstflag esc", o_tdata_c, ESC);
    @(posedge clk); #1;
    o_tready = 1'b0;
    @(negedge clk);
    chk("rstflag flag", o_tdata_c, 64'h00000003_00000001);
    chk("rstflag i_tready", {63'b0, i_tready_c}, 64'd0);
    @(posedge clk); #1;
    chk("rstflag stall", o_tdata_c, 64'h00000003_00000001);
    reset = 1'b1;
    #1;
    chk("rstflag o_tvalid", {63'b0, o_tvalid_c}, 64'd1);
    chk("rstflag o_tdata idle", o_tdata_c, ESC);
    chk("rstflag i_tready idle", {63'b0, i_tready_c}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dir_d = '{V}; dir_l = '{1};
    exp_c = '{ESC, 64'h1, V};
    exp_n = '{ESC, 64'h1, V};
    run_dir("after_reset");

    // Random phase: source packets and the expected encoded streams
    csum = 32'h0;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int w = 0; w < len; w++) begin
        logic [63:0] d;
        bit l;
        d = ($urandom_range(0, 7) == 0) ? ESC : {$urandom, $urandom};
        l = (w == len - 1);
        src_d.push_back(d);
        src_l.push_back(l);
        if (l || d == ESC) begin
          sb_c.push_back(ESC); sb_c.push_back({csum, 31'b0, l}); sb_c.push_back(d);
          sb_n.push_back(ESC); sb_n.push_back({32'h0, 31'b0, l}); sb_n.push_back(d);
        end else begin
          sb_c.push_back(d);
          sb_n.push_back(d);
        end
        csum = l ? 32'h0 : (csum ^ fold(d));
      end
    end

    check_en = 1'b1;
    idx = 0; cyc = 0;
    i_tvalid = 1'b0;
    while ((idx < src_d.size() || sb_c.size() != 0 || sb_n.size() != 0) && cyc < 60000) begin
      if (!i_tvalid && idx < src_d.size() && $urandom_range(0, 3) != 0) begin
        i_tvalid = 1'b1;
        i_tdata  = src_d[idx];
        i_tlast  = src_l[idx];
      end
      o_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fire = i_tvalid & i_tready_c;
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        idx++;
        i_tvalid = 1'b0;
      end
    end
    i_tvalid = 1'b0;
    @(negedge clk);
    check_en = 1'b0;
    chk("rnd consumed", idx, src_d.size());
    chk("rnd sb_c empty", sb_c.size(), 0);
    chk("rnd sb_n empty", sb_n.size(), 0);
    chk("rnd decoded", dec_idx, src_d.size());
    $display("random: %0d words in %0d cycles", idx, cyc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
